dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Two-requester arbiter sharing the single-port data memory between the pipelined core's MEM stage and a program/data loader port used for test preload and debug.
- Core has default priority.
- The loader is guaranteed service after a bounded wait.
- When the core loses arbitration it sees a stall, which the hazard logic uses to freeze the pipeline.
- Sits between the datapath (ALU result / rd2 / MemWrite of MEM stage) and the data memory (sync write, combinational read).

Parameters:
ADDR_W, 32, address width of both requesters and memory
DATA_W, 32, data width
MAX_WAIT, 4, max consecutive cycles a pending loader request may lose to the core (legal 1..15)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
core_req  in  1  MEM-stage access this cycle (load or store)
core_we  in  1  core store
core_addr  in  ADDR_W  core address
core_wdata  in  DATA_W  core store data
core_rdata  out  DATA_W  core load data, combinational from memory
core_stall  out  1  core access not served this cycle; hold MEM stage
ldr_req  in  1  loader access request; held with stable addr/data until ldr_gnt
ldr_we  in  1  loader write
ldr_addr  in  ADDR_W  loader address
ldr_wdata  in  DATA_W  loader write data
ldr_gnt  out  1  loader access performed this cycle
ldr_rdata  out  DATA_W  registered loader read data
ldr_rvalid  out  1  ldr_rdata valid, one-cycle pulse
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data (combinational)

Behaviour:
- One access per cycle. Grant is decided combinationally from requests and wait_cnt.
- Loader wins when ldr_req & (~core_req | wait_cnt == MAX_WAIT). Otherwise the core wins if core_req.
- core_stall = core_req & ldr_gnt. ldr_gnt = the loader-win condition.
- Memory mux:
  - Loader owner: mem_addr/mem_wdata/mem_we = ldr_addr/ldr_wdata/ldr_we.
  - Otherwise: core fields, with mem_we = core_req & core_we.
  - mem_we is never 1 without a granted request.
- core_rdata = mem_rdata, always, zero latency. Valid only when core_req & ~core_stall.
- wait_cnt, 4-bit:
  - cleared on reset, on ldr_gnt, or when ~ldr_req;
  - else increments while ldr_req & core_req & ~ldr_gnt;
  - saturates at MAX_WAIT.
- Loader read: on ldr_gnt & ~ldr_we, ldr_rdata <= mem_rdata and ldr_rvalid <= 1 next cycle. Otherwise ldr_rvalid <= 0 and ldr_rdata holds.
- Loader write: ldr_rvalid stays 0.
- Back-to-back loader grants: rvalid may stay high on consecutive cycles, one per read.
- Same-address conflict: the loser is served after the winner's write, so it observes the new data.
  - A core load stalled by a loader write to the same address returns the written data next cycle.
- Reset outputs: ldr_rvalid=0, ldr_rdata=0, wait_cnt=0. Combinational outputs follow inputs; with no requests, mem_we=0 and mem_addr=core_addr.
- Reset mid-operation: a pending ldr_rvalid is dropped, wait_cnt is cleared, and no write occurs in the reset cycle (mem_we forced 0 while rst=1).
- Loader dropping ldr_req before grant: wait_cnt clears; no access performed.

Optional Feature:
- Macro DMEM_ARB_STATS_EN. When defined, adds outputs:
  - stat_core_stalls (32b): counts cycles with core_stall=1;
  - stat_ldr_grants (32b): counts ldr_gnt cycles;
  - both cleared by rst, wrap at 2^32.
- Undefined: ports and counters absent, all other behaviour identical.

Test Plan:
- Core only: core_req=1, core_we=1, addr 0x10, data 0xDEADBEEF; next cycle read 0x10 -> mem_we pulse, core_rdata=0xDEADBEEF, core_stall=0 throughout.
- Loader only: ldr write 0x20=0x12345678, then ldr read 0x20 -> ldr_gnt each cycle, ldr_rvalid=1 one cycle after the read with ldr_rdata=0x12345678.
- Starvation bound (MAX_WAIT=4): core_req held high, ldr_req raised at cycle 0 -> core wins cycles 0-3, ldr_gnt=1 and core_stall=1 at cycle 4, core wins again at cycle 5.
- Same-address conflict: core load 0x40 (mem=0x1) with forced loader write 0x40=0x2 -> core stalls one cycle, then core_rdata=0x2.
- Reset mid-read: loader read granted, rst asserted next cycle -> ldr_rvalid=0, ldr_rdata=0, mem_we=0 during reset, wait_cnt=0 after.
- With DMEM_ARB_STATS_EN: scenario 3 -> stat_core_stalls=1, stat_ldr_grants=1.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bundles the core, loader and data-memory signals that meet at the dmem arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface dmem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              core_req;
    logic              core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic [DATA_W-1:0] core_rdata;
    logic              core_stall;

    logic              ldr_req;
    logic              ldr_we;
    logic [ADDR_W-1:0] ldr_addr;
    logic [DATA_W-1:0] ldr_wdata;
    logic              ldr_gnt;
    logic [DATA_W-1:0] ldr_rdata;
    logic              ldr_rvalid;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        output core_rdata, core_stall,
        input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
        output ldr_gnt, ldr_rdata, ldr_rvalid,
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata,
        input  core_rdata, core_stall,
        output ldr_req, ldr_we, ldr_addr, ldr_wdata,
        input  ldr_gnt, ldr_rdata, ldr_rvalid,
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Core/loader arbiter for the single-port data memory; core has priority, loader waits at most
// MAX_WAIT cycles. Define DMEM_ARB_STATS_EN to add stall/grant statistic counters.
module dmem_arbiter #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic                clk,
    input  logic                rst,
`ifdef DMEM_ARB_STATS_EN
    output logic [31:0]         stat_core_stalls,
    output logic [31:0]         stat_ldr_grants,
`endif
    dmem_arbiter_if.slave       bus
);
    localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

    logic              ldrWin;
    logic [3:0]        waitCnt_q, waitCnt_d;
    logic              ldrRvalid_q, ldrRvalid_d;
    logic [DATA_W-1:0] ldrRdata_q, ldrRdata_d;

    // Grant and memory mux are purely combinational so the winner accesses memory this cycle.
    always_comb begin
        ldrWin         = bus.ldr_req & (~bus.core_req | (waitCnt_q == MaxWait));
        bus.ldr_gnt    = ldrWin;
        bus.core_stall = bus.core_req & ldrWin;
        bus.core_rdata = bus.mem_rdata;
        if (ldrWin) begin
            bus.mem_addr  = bus.ldr_addr;
            bus.mem_wdata = bus.ldr_wdata;
            bus.mem_we    = bus.ldr_we;
        end else begin
            bus.mem_addr  = bus.core_addr;
            bus.mem_wdata = bus.core_wdata;
            bus.mem_we    = bus.core_req & bus.core_we;
        end
        // No memory write may land in a reset cycle.
        if (rst) begin
            bus.mem_we = 1'b0;
        end
    end

    always_comb begin
        waitCnt_d = waitCnt_q;
        if (ldrWin || !bus.ldr_req) begin
            waitCnt_d = 4'd0;
        end else if (bus.core_req && waitCnt_q < MaxWait) begin
            waitCnt_d = waitCnt_q + 4'd1;
        end
    end

    always_comb begin
        ldrRvalid_d = 1'b0;
        ldrRdata_d  = ldrRdata_q;
        if (ldrWin && !bus.ldr_we) begin
            ldrRvalid_d = 1'b1;
            ldrRdata_d  = bus.mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            waitCnt_q   <= 4'd0;
            ldrRvalid_q <= 1'b0;
            ldrRdata_q  <= '0;
        end else begin
            waitCnt_q   <= waitCnt_d;
            ldrRvalid_q <= ldrRvalid_d;
            ldrRdata_q  <= ldrRdata_d;
        end
    end

    assign bus.ldr_rvalid = ldrRvalid_q;
    assign bus.ldr_rdata  = ldrRdata_q;

`ifdef DMEM_ARB_STATS_EN
    logic [31:0] statStalls_q, statGrants_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            statStalls_q <= '0;
            statGrants_q <= '0;
        end else begin
            if (bus.core_stall) statStalls_q <= statStalls_q + 32'd1;
            if (ldrWin)         statGrants_q <= statGrants_q + 32'd1;
        end
    end

    assign stat_core_stalls = statStalls_q;
    assign stat_ldr_grants  = statGrants_q;
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a sync-write / comb-read memory model.
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef DMEM_ARB_STATS_EN
    logic [31:0] statStalls, statGrants;
`endif

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
        .clk              (clk),
        .rst              (rst),
`ifdef DMEM_ARB_STATS_EN
        .stat_core_stalls (statStalls),
        .stat_ldr_grants  (statGrants),
`endif
        .bus              (bus)
    );

    logic [31:0] mem [0:255];
    always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
    assign bus.mem_rdata = mem[bus.mem_addr[7:0]];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        rst = 1'b1;
        bus.core_req = 0; bus.core_we = 0; bus.core_addr = 32'h55; bus.core_wdata = 0;
        bus.ldr_req = 0;  bus.ldr_we = 0;  bus.ldr_addr = 0;      bus.ldr_wdata = 0;
        nextCycle();
        #1;
        check("rst_rvalid", 32'(bus.ldr_rvalid), 32'd0);
        check("rst_rdata", bus.ldr_rdata, 32'd0);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'h55);
        check("rst_gnt", 32'(bus.ldr_gnt), 32'd0);
        rst = 1'b0;
        nextCycle();

        // Core store then load
        bus.core_req = 1; bus.core_we = 1; bus.core_addr = 32'h10; bus.core_wdata = 32'hDEADBEEF;
        #1;
        check("core_st_we", 32'(bus.mem_we), 32'd1);
        check("core_st_addr", bus.mem_addr, 32'h10);
        check("core_st_stall", 32'(bus.core_stall), 32'd0);
        nextCycle();
        bus.core_we = 0;
        #1;
        check("core_ld_data", bus.core_rdata, 32'hDEADBEEF);
        check("core_ld_we", 32'(bus.mem_we), 32'd0);
        check("core_ld_stall", 32'(bus.core_stall), 32'd0);
        nextCycle();
        bus.core_req = 0;

        // Loader write then read
        bus.ldr_req = 1; bus.ldr_we = 1; bus.ldr_addr = 32'h20; bus.ldr_wdata = 32'h12345678;
        #1;
        check("ldr_wr_gnt", 32'(bus.ldr_gnt), 32'd1);
        check("ldr_wr_we", 32'(bus.mem_we), 32'd1);
        check("ldr_wr_addr", bus.mem_addr, 32'h20);
        nextCycle();
        check("ldr_wr_norv", 32'(bus.ldr_rvalid), 32'd0);
        bus.ldr_we = 0;
        #1;
        check("ldr_rd_gnt", 32'(bus.ldr_gnt), 32'd1);
        check("ldr_rd_we", 32'(bus.mem_we), 32'd0);
        nextCycle();
        bus.ldr_req = 0;
        check("ldr_rd_rv", 32'(bus.ldr_rvalid), 32'd1);
        check("ldr_rd_data", bus.ldr_rdata, 32'h12345678);
        nextCycle();
        check("ldr_rv_pulse", 32'(bus.ldr_rvalid), 32'd0);
        check("ldr_rd_hold", bus.ldr_rdata, 32'h12345678);

        // Reset in the cycle after a granted loader read; core store attempted during reset
        bus.ldr_req = 1; bus.ldr_we = 0; bus.ldr_addr = 32'h20;
        #1;
        check("mid_gnt", 32'(bus.ldr_gnt), 32'd1);
        nextCycle();
        rst = 1; bus.ldr_req = 0;
        bus.core_req = 1; bus.core_we = 1; bus.core_addr = 32'h30; bus.core_wdata = 32'hBAD;
        #1;
        check("mid_rst_we", 32'(bus.mem_we), 32'd0);
        nextCycle();
        check("mid_rst_rv", 32'(bus.ldr_rvalid), 32'd0);
        check("mid_rst_rd", bus.ldr_rdata, 32'd0);
        rst = 0; bus.core_we = 0;
        #1;
        check("mid_no_write", bus.core_rdata, 32'd0);

        // Starvation bound right after reset: core wins 4 cycles, loader on the 5th
        bus.core_addr = 32'h10;
        bus.ldr_req = 1; bus.ldr_we = 0; bus.ldr_addr = 32'h20;
        for (int cyc = 0; cyc < 6; cyc++) begin
            #1;
            check($sformatf("starve_gnt%0d", cyc), 32'(bus.ldr_gnt), (cyc == 4) ? 32'd1 : 32'd0);
            check($sformatf("starve_stall%0d", cyc), 32'(bus.core_stall),
                  (cyc == 4) ? 32'd1 : 32'd0);
            check($sformatf("starve_addr%0d", cyc), bus.mem_addr, (cyc == 4) ? 32'h20 : 32'h10);
            nextCycle();
            if (cyc == 4) begin
                bus.ldr_req = 0;
                check("starve_rv", 32'(bus.ldr_rvalid), 32'd1);
                check("starve_rd", bus.ldr_rdata, 32'h12345678);
            end
        end
`ifdef DMEM_ARB_STATS_EN
        check("stat_stalls", statStalls, 32'd1);
        check("stat_grants", statGrants, 32'd1);
`endif
        bus.core_req = 0;

        // Same-address conflict: core load 0x40 loses to a forced loader write of 0x2
        mem[8'h40] = 32'h1;
        nextCycle();
        bus.core_req = 1; bus.core_we = 0; bus.core_addr = 32'h40;
        bus.ldr_req = 1; bus.ldr_we = 1; bus.ldr_addr = 32'h40; bus.ldr_wdata = 32'h2;
        for (int cyc = 0; cyc < 4; cyc++) begin
            #1;
            check($sformatf("conf_old%0d", cyc), bus.core_rdata, 32'h1);
            nextCycle();
        end
        #1;
        check("conf_stall", 32'(bus.core_stall), 32'd1);
        check("conf_ldr_we", 32'(bus.mem_we), 32'd1);
        nextCycle();
        bus.ldr_req = 0;
        #1;
        check("conf_new", bus.core_rdata, 32'h2);
        check("conf_nostall", 32'(bus.core_stall), 32'd0);
        check("conf_wr_norv", 32'(bus.ldr_rvalid), 32'd0);
        bus.core_req = 0;
        nextCycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
